event_sense: RTL and testbench

Front-end stage that feeds half-rate recovery. It synchronises the raw incoming clock/data line into the system domain, deglitches it, and emits single-cycle edge events with polarity. It also runs the free-running rate counter that event filtering compares against its frequency bands. It captures the last measured half-period for rate tracking and lock-in.

---
 rtl/sir_clks_alot_pkg.sv | 28 ++
 rtl/signal_synchronizer.sv | 38 +++
 rtl/event_sense.sv | 155 +++++++++++++++
 tb/tb_event_sense.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sir_clks_alot_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : sir_clks_alot_pkg                                      |
// | Description : Shared types for the clock-recovery front end.         |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package sir_clks_alot_pkg;

  localparam int RATE_WIDTH = 16;

  typedef logic [RATE_WIDTH-1:0] rate_t;

  localparam rate_t RATE_MAX = '1;

  typedef struct packed {
    logic clk;
    logic n_rst;
  } sys_dom_t;

  typedef enum logic [1:0] {
    DISABLED  = 2'd0,
    PRIME     = 2'd1,
    STABLE    = 2'd2,
    CANDIDATE = 2'd3
  } sense_state_e;

endpackage
`default_nettype wire

// File: rtl/signal_synchronizer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : signal_synchronizer                                    |
// | Description : Multi-flop metastability synchroniser for one bit.     |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module signal_synchronizer
  import sir_clks_alot_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  sys_dom_t sys_dom_i,
  input  logic     raw_i,
  output logic     sync_o
);

  // A chain shorter than two flops gives no metastability protection.
  localparam int c_stages = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic                clk;
  logic                rst_n;
  logic [c_stages-1:0] r_chain;

  assign clk   = sys_dom_i.clk;
  assign rst_n = sys_dom_i.n_rst;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[c_stages-2:0], raw_i};
    end
  end

  assign sync_o = r_chain[c_stages-1];

endmodule
`default_nettype wire

// File: rtl/event_sense.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : event_sense                                            |
// | Description : Synchronise, deglitch and timestamp edges of a raw     |
// |               line; emits polarity-tagged edge events.               |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module event_sense
  import sir_clks_alot_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int COUNTER_WIDTH  = 16,
  parameter int DEGLITCH_WIDTH = 4
) (
  input  sys_dom_t                  sys_dom_i,
  input  logic                      sense_en_i,
  input  logic                      clear_state_i,
  input  logic [DEGLITCH_WIDTH-1:0] deglitch_cycles_i,
  input  logic                      primary_clk_i,
  output logic                      sense_event_o,
  output logic                      event_polarity_o,
  output logic [COUNTER_WIDTH-1:0]  current_rate_counter_o,
  output logic [COUNTER_WIDTH-1:0]  last_half_rate_o,
  output logic                      last_half_rate_valid_o,
  output logic                      rate_saturated_o
);

  localparam logic [COUNTER_WIDTH-1:0]  c_rate_max   = '1;
  localparam logic [COUNTER_WIDTH-1:0]  c_rate_one   = COUNTER_WIDTH'(1);
  localparam logic [DEGLITCH_WIDTH-1:0] c_glitch_one = DEGLITCH_WIDTH'(1);

  logic                      clk;
  logic                      rst_n;
  logic                      w_sync_lvl;
  logic                      w_lvl_diff;
  logic                      w_accept;
  sense_state_e              r_state;
  sense_state_e              w_state_nxt;
  logic                      r_acc_lvl;
  logic [DEGLITCH_WIDTH-1:0] r_glitch_cnt;
  logic [DEGLITCH_WIDTH-1:0] w_glitch_nxt;
  logic                      r_event;
  logic                      r_polarity;
  logic                      r_valid;
  logic [COUNTER_WIDTH-1:0]  r_cnt;
  logic [COUNTER_WIDTH-1:0]  r_last;
  logic [COUNTER_WIDTH-1:0]  w_cnt_nxt;

  assign clk   = sys_dom_i.clk;
  assign rst_n = sys_dom_i.n_rst;

  signal_synchronizer #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .sys_dom_i (sys_dom_i),
    .raw_i     (primary_clk_i),
    .sync_o    (w_sync_lvl)
  );

  assign w_lvl_diff = (w_sync_lvl != r_acc_lvl);

  always_comb begin
    w_state_nxt  = r_state;
    w_glitch_nxt = r_glitch_cnt;
    w_accept     = 1'b0;
    if (!sense_en_i) begin
      w_state_nxt = DISABLED;
    end else if (clear_state_i) begin
      w_state_nxt = PRIME;
    end else begin
      unique case (r_state)
        DISABLED: w_state_nxt = PRIME;
        PRIME:    w_state_nxt = STABLE;
        STABLE: begin
          if (w_lvl_diff) begin
            if (deglitch_cycles_i == '0) begin
              w_accept = 1'b1;
            end else begin
              w_glitch_nxt = c_glitch_one;
              w_state_nxt  = CANDIDATE;
            end
          end
        end
        CANDIDATE: begin
          // The threshold is compared live so a reconfiguration applies mid-candidate.
          if (!w_lvl_diff) begin
            w_state_nxt = STABLE;
          end else if (r_glitch_cnt >= deglitch_cycles_i) begin
            w_accept    = 1'b1;
            w_state_nxt = STABLE;
          end else begin
            w_glitch_nxt = r_glitch_cnt + c_glitch_one;
          end
        end
        default: w_state_nxt = DISABLED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= DISABLED;
      r_acc_lvl    <= 1'b0;
      r_glitch_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_glitch_cnt <= w_glitch_nxt;
      if ((r_state == PRIME) || w_accept) begin
        r_acc_lvl <= w_sync_lvl;
      end
    end
  end

  // Counter restarts at 1 the cycle after a pulse, so the pulse cycle shows the full spacing.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (r_event) begin
      w_cnt_nxt = c_rate_one;
    end else if ((r_cnt != '0) && (r_cnt != c_rate_max)) begin
      w_cnt_nxt = r_cnt + c_rate_one;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_event    <= 1'b0;
      r_polarity <= 1'b0;
      r_cnt      <= '0;
      r_last     <= '0;
      r_valid    <= 1'b0;
    end else if (!sense_en_i || clear_state_i) begin
      r_event <= 1'b0;
      r_cnt   <= '0;
      r_last  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_event <= w_accept;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_polarity <= w_sync_lvl;
        r_last     <= w_cnt_nxt;
        r_valid    <= (w_cnt_nxt != '0);
      end
    end
  end

  assign sense_event_o          = r_event;
  assign event_polarity_o       = r_polarity;
  assign current_rate_counter_o = r_cnt;
  assign last_half_rate_o       = r_last;
  assign last_half_rate_valid_o = r_valid;
  assign rate_saturated_o       = (r_cnt == c_rate_max);

endmodule
`default_nettype wire

// File: tb/tb_event_sense.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_event_sense                                         |
// | Description : Self-checking bench for event_sense with a timestamp   |
// |               based reference model.                                 |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module tb_event_sense;
  import sir_clks_alot_pkg::*;

  localparam int SYNC     = 2;
  localparam int CW       = 16;
  localparam int DW       = 4;
  localparam int CNT_MAX  = 65535;

  logic           clk = 1'b0;
  logic           n_rst;
  sys_dom_t       dom;
  logic           en, clr, raw;
  logic [DW-1:0]  dg;
  logic           sense_event_o, event_polarity_o;
  logic [CW-1:0]  current_rate_counter_o, last_half_rate_o;
  logic           last_half_rate_valid_o, rate_saturated_o;

  int vectors = 0;
  int miscompares = 0;

  assign dom.clk   = clk;
  assign dom.n_rst = n_rst;

  always #5 clk = ~clk;

  event_sense #(
    .SYNC_STAGES    (SYNC),
    .COUNTER_WIDTH  (CW),
    .DEGLITCH_WIDTH (DW)
  ) dut (
    .sys_dom_i              (dom),
    .sense_en_i             (en),
    .clear_state_i          (clr),
    .deglitch_cycles_i      (dg),
    .primary_clk_i          (raw),
    .sense_event_o          (sense_event_o),
    .event_polarity_o       (event_polarity_o),
    .current_rate_counter_o (current_rate_counter_o),
    .last_half_rate_o       (last_half_rate_o),
    .last_half_rate_valid_o (last_half_rate_valid_o),
    .rate_saturated_o       (rate_saturated_o)
  );

  // Reference model: the line seen SYNC edges late, accepted once it has
  // disagreed with the accepted level for dg+1 consecutive samples; rates
  // are derived from pulse timestamps.
  bit     m_q[$];
  int     m_mode;            // 0 off, 1 latch level at next edge, 2 tracking
  bit     m_acc;
  int     m_run;
  bit     m_have;
  longint m_prev;
  longint k = 0;
  bit     exp_evt, exp_pol, exp_valid;
  int     exp_cnt, exp_last;

  int ev_total;
  int ev_cnt[$];
  int ev_last[$];
  bit ev_valid[$];
  bit ev_pol[$];

  function automatic int span(input longint d);
    return (d > CNT_MAX) ? CNT_MAX : int'(d);
  endfunction

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < SYNC; i++) m_q.push_back(1'b0);
    m_mode = 0; m_acc = 0; m_run = 0; m_have = 0; m_prev = 0;
    exp_evt = 0; exp_pol = 0; exp_valid = 0; exp_cnt = 0; exp_last = 0;
  endtask

  task automatic model_edge();
    bit s;
    bit pulse;
    k++;
    if (!n_rst) begin
      model_reset();
      return;
    end
    s = m_q.pop_front();
    m_q.push_back(raw);
    pulse = 0;
    if (!en) begin
      m_mode = 0; m_have = 0;
    end else if (clr) begin
      m_mode = 1; m_have = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      m_acc = s; m_run = 0; m_mode = 2;
    end else begin
      m_run = (s != m_acc) ? m_run + 1 : 0;
      if (m_run > int'(dg)) begin
        pulse = 1; m_acc = s; m_run = 0;
      end
    end
    exp_evt = pulse;
    if (!en || clr) begin
      exp_cnt = 0; exp_last = 0; exp_valid = 0;
    end else if (pulse) begin
      exp_cnt   = m_have ? span(k - m_prev) : 0;
      exp_last  = exp_cnt;
      exp_valid = m_have;
      exp_pol   = s;
      m_have    = 1;
      m_prev    = k;
    end else begin
      exp_cnt = m_have ? span(k - m_prev) : 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    chk("sense_event", 32'(sense_event_o), 32'(exp_evt));
    chk("polarity", 32'(event_polarity_o), 32'(exp_pol));
    chk("rate_counter", 32'(current_rate_counter_o), 32'(exp_cnt));
    chk("last_half_rate", 32'(last_half_rate_o), 32'(exp_last));
    chk("valid", 32'(last_half_rate_valid_o), 32'(exp_valid));
    chk("saturated", 32'(rate_saturated_o), 32'(exp_cnt == CNT_MAX));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
    if (sense_event_o) begin
      ev_total++;
      ev_cnt.push_back(int'(current_rate_counter_o));
      ev_last.push_back(int'(last_half_rate_o));
      ev_valid.push_back(last_half_rate_valid_o);
      ev_pol.push_back(event_polarity_o);
    end
  endtask

  task automatic tally_clear();
    ev_total = 0;
    ev_cnt.delete(); ev_last.delete(); ev_valid.delete(); ev_pol.delete();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_event(input string tag, input int limit, output int waited);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!sense_event_o && n < limit);
    waited = n;
    vectors++;
    assert (sense_event_o === 1'b1) else begin
      miscompares++;
      $error("FAIL %s timeout observed=%0d cycles expected=event", tag, n);
    end
  endtask

  task automatic pulse_clear();
    clr = 1; cycle(); clr = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    int hold;
    n_rst = 0; en = 0; clr = 0; dg = '0; raw = 0;
    model_reset();
    tally_clear();
    cycles(3);
    n_rst = 1;
    cycles(2);

    // Minimum latency with no deglitch.
    en = 1;
    cycles(6);
    raw = 1;
    wait_event("latency_wait", 20, w);
    chk("latency", 32'(w), 32'(SYNC + 1));
    chk("latency_pol", 32'(event_polarity_o), 32'd1);

    // 20-cycle square wave, deglitch 2.
    dg = 4'd2;
    pulse_clear();
    cycles(5);
    tally_clear();
    for (int h = 0; h < 8; h++) begin
      raw = (h % 2 == 1);
      cycles(20);
    end
    cycles(10);
    chk("sq_count", 32'(ev_total), 32'd8);
    if (ev_total == 8) begin
      chk("sq_first_valid", 32'(ev_valid[0]), 32'd0);
      for (int e = 1; e < 8; e++) begin
        chk("sq_cnt", 32'(ev_cnt[e]), 32'd20);
        chk("sq_last", 32'(ev_last[e]), 32'd20);
        chk("sq_valid", 32'(ev_valid[e]), 32'd1);
      end
      for (int e = 0; e < 8; e++) chk("sq_pol", 32'(ev_pol[e]), 32'(e % 2));
    end

    // Short glitches rejected, 4-cycle pulse accepted, deglitch 3.
    dg = 4'd3; raw = 0;
    pulse_clear();
    cycles(10);
    tally_clear();
    raw = 1; cycles(1); raw = 0; cycles(10);
    raw = 1; cycles(2); raw = 0; cycles(10);
    chk("glitch_rejected", 32'(ev_total), 32'd0);
    raw = 1; cycles(4); raw = 0; cycles(12);
    chk("pulse4_count", 32'(ev_total), 32'd2);
    if (ev_total == 2) begin
      chk("pulse4_rise", 32'(ev_pol[0]), 32'd1);
      chk("pulse4_fall", 32'(ev_pol[1]), 32'd0);
    end

    // Clear coinciding with an accepted edge.
    dg = 4'd0; raw = 1;
    pulse_clear();
    cycles(8);
    raw = 0;
    cycles(2);
    clr = 1; cycle(); clr = 0;
    chk("clr_no_pulse", 32'(sense_event_o), 32'd0);
    chk("clr_cnt", 32'(current_rate_counter_o), 32'd0);
    chk("clr_valid", 32'(last_half_rate_valid_o), 32'd0);
    tally_clear();
    cycles(10);
    chk("clr_discarded", 32'(ev_total), 32'd0);
    raw = 1;
    wait_event("clr_ref_wait", 20, w);
    chk("clr_ref_valid", 32'(last_half_rate_valid_o), 32'd0);
    cycles(14);
    raw = 0;
    wait_event("clr_meas_wait", 20, w);
    chk("clr_meas_valid", 32'(last_half_rate_valid_o), 32'd1);
    chk("clr_meas_last", 32'(last_half_rate_o), 32'd17);

    // Counter saturation.
    cycles(65540);
    chk("sat_cnt", 32'(current_rate_counter_o), 32'hFFFF);
    chk("sat_flag", 32'(rate_saturated_o), 32'd1);
    raw = 1;
    wait_event("sat_wait", 20, w);
    chk("sat_capture", 32'(last_half_rate_o), 32'hFFFF);
    cycle();
    chk("sat_cleared", 32'(rate_saturated_o), 32'd0);
    chk("sat_restart", 32'(current_rate_counter_o), 32'd1);

    // Enable with line high, then reset during a candidate.
    en = 0; raw = 1;
    cycles(6);
    tally_clear();
    en = 1;
    cycles(10);
    chk("prime_no_spurious", 32'(ev_total), 32'd0);
    dg = 4'd6; raw = 0;
    cycles(4);
    #3 n_rst = 0;
    model_reset();
    #1;
    chk("rst_event", 32'(sense_event_o), 32'd0);
    chk("rst_cnt", 32'(current_rate_counter_o), 32'd0);
    chk("rst_last", 32'(last_half_rate_o), 32'd0);
    chk("rst_valid", 32'(last_half_rate_valid_o), 32'd0);
    chk("rst_pol", 32'(event_polarity_o), 32'd0);
    cycles(2);
    n_rst = 1;
    tally_clear();
    cycles(20);
    chk("rst_no_event", 32'(ev_total), 32'd0);
    raw = 1;
    wait_event("rst_edge_wait", 30, w);
    chk("rst_edge_pol", 32'(event_polarity_o), 32'd1);

    // Randomised traffic against the model.
    hold = 0;
    for (int c = 0; c < 1500; c++) begin
      if (hold == 0) begin
        raw  = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 25);
        if ($urandom_range(0, 3) == 0) dg = DW'($urandom_range(0, 4));
      end
      hold--;
      clr = ($urandom_range(0, 59) == 0);
      en  = ($urandom_range(0, 149) != 0);
      cycle();
    end
    clr = 0; en = 1;
    cycles(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
